graph_mem_arbiter: RTL and testbench

//  Shares one read port of graph_memory between N_REQ requesters (graph_fetch

---
 rtl/graph_mem_arbiter_pkg.sv | 18 +
 rtl/graph_mem_arbiter_rr_arbiter.sv | 33 +++
 rtl/graph_mem_arbiter.sv | 93 +++++++++
 tb/tb_graph_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/graph_mem_arbiter_pkg.sv
// Shared types and helpers for the graph memory arbiters.
package graph_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int N_REQ_DEF  = 4;
  localparam int MAX_REQ    = 32;

  typedef logic [$clog2(N_REQ_DEF)-1:0] req_id_t;

  // Callers size-cast the result down to their own requester count.
  function automatic logic [MAX_REQ-1:0] onehot_from_id(input int unsigned id);
    logic [MAX_REQ-1:0] one;
    one = {{(MAX_REQ-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/graph_mem_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr (wrapping) wins.
module rr_arbiter
  import graph_mem_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] id,
  output logic           any
);

  int idx;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (en && !any && req[idx]) begin
        any   = 1'b1;
        id    = IDW'(idx);
        grant = N'(onehot_from_id(idx));
      end
    end
  end

endmodule

// File: rtl/graph_mem_arbiter.sv
// Shares one graph_memory read port among N_REQ fetch units; in-order
// responses are steered back using a FIFO of requester tags.
module graph_mem_arbiter
  import graph_mem_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  localparam int IDW         = $clog2(N_REQ),
  localparam int PW          = $clog2(MAX_INFLIGHT),
  localparam int CW          = PW + 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [N_REQ-1:0]              req_valid_in,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr_in,
  output logic [N_REQ-1:0]              req_ready_out,
  output logic [N_REQ-1:0]              resp_valid_out,
  output logic [DATA_W-1:0]             resp_data_out,
  output logic [ADDR_W-1:0]             mem_req_out,
  output logic                          mem_valid_out,
  input  logic [DATA_W-1:0]             mem_data_in,
  input  logic                          mem_valid_in,
  output logic [CW-1:0]                 inflight_out,
  output logic                          err_out
);

  logic [CW-1:0]  count;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win_id;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [IDW-1:0] tag_mem [MAX_INFLIGHT];
  logic           grant_any;
  logic           en;
  logic           push;
  logic           pop;
  logic           orphan;

  // Ready comes from the registered count only, so a pop never frees a slot
  // for a grant in the same cycle. Held low during reset so outputs read 0.
  assign en = rst_in && (count < CW'(MAX_INFLIGHT));

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_rr (
    .req   (req_valid_in),
    .ptr   (rr_ptr),
    .en    (en),
    .grant (req_ready_out),
    .id    (win_id),
    .any   (grant_any)
  );

  assign push         = grant_any;
  assign pop          = mem_valid_in && (count != '0);
  assign orphan       = mem_valid_in && (count == '0);
  assign inflight_out = count;

  always_ff @(posedge clk_in) begin
    if (push) tag_mem[wr_ptr] <= win_id;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count          <= '0;
      rr_ptr         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      mem_req_out    <= '0;
      mem_valid_out  <= 1'b0;
      resp_valid_out <= '0;
      resp_data_out  <= '0;
      err_out        <= 1'b0;
    end else begin
      count         <= count + CW'(push) - CW'(pop);
      mem_valid_out <= push;
      if (push) begin
        mem_req_out <= req_addr_in[win_id];
        wr_ptr      <= wr_ptr + 1'b1;
        rr_ptr      <= (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
      end
      if (pop) begin
        resp_valid_out <= N_REQ'(onehot_from_id(int'(tag_mem[rd_ptr])));
        resp_data_out  <= mem_data_in;
        rd_ptr         <= rd_ptr + 1'b1;
      end else begin
        resp_valid_out <= '0;
      end
      if (orphan) err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Directed bench for graph_mem_arbiter with default parameters.
module tb_graph_mem_arbiter;
  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [3:0]       req_valid_in;
  logic [3:0][31:0] req_addr_in;
  logic [3:0]       req_ready_out;
  logic [3:0]       resp_valid_out;
  logic [31:0]      resp_data_out;
  logic [31:0]      mem_req_out;
  logic             mem_valid_out;
  logic [31:0]      mem_data_in;
  logic             mem_valid_in;
  logic [3:0]       inflight_out;
  logic             err_out;

  int total = 0;
  int bad   = 0;

  graph_mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in),
    .req_addr_in(req_addr_in), .req_ready_out(req_ready_out),
    .resp_valid_out(resp_valid_out), .resp_data_out(resp_data_out),
    .mem_req_out(mem_req_out), .mem_valid_out(mem_valid_out),
    .mem_data_in(mem_data_in), .mem_valid_in(mem_valid_in),
    .inflight_out(inflight_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] addr_of(int r);
    return 32'h100 + 32'(r) * 32'h10;
  endfunction

  function automatic logic [3:0] oh(int r);
    logic [3:0] one;
    one = 4'b0001;
    return one << (r % 4);
  endfunction

  task automatic do_reset;
    rst_in = 1'b0; req_valid_in = '0; mem_valid_in = 1'b0;
    tick;
    rst_in = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    total++; if (mem_valid_out !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%b exp=0", mem_valid_out); end
    total++; if (mem_req_out !== 32'h0) begin bad++; $display("FAIL rst_mem_req got=%h exp=0", mem_req_out); end
    total++; if (resp_valid_out !== 4'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0000", resp_valid_out); end
    total++; if (resp_data_out !== 32'h0) begin bad++; $display("FAIL rst_resp_data got=%h exp=0", resp_data_out); end
    total++; if (inflight_out !== 4'd0) begin bad++; $display("FAIL rst_inflight got=%0d exp=0", inflight_out); end
    total++; if (err_out !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_out); end
    req_valid_in = 4'b1111;
    #1;
    total++; if (req_ready_out !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0000", req_ready_out); end
    req_valid_in = '0;
    tick; tick;
    rst_in = 1'b1;
    #1;
  endtask

  task automatic test_single;
    req_valid_in = 4'b0001; req_addr_in[0] = 32'h10;
    #1;
    total++; if (req_ready_out !== 4'b0001) begin bad++; $display("FAIL t1_ready got=%b exp=0001", req_ready_out); end
    tick;
    req_valid_in = '0;
    total++; if (mem_valid_out !== 1'b1) begin bad++; $display("FAIL t1_mem_valid got=%b exp=1", mem_valid_out); end
    total++; if (mem_req_out !== 32'h10) begin bad++; $display("FAIL t1_mem_req got=%h exp=10", mem_req_out); end
    total++; if (inflight_out !== 4'd1) begin bad++; $display("FAIL t1_inflight got=%0d exp=1", inflight_out); end
    tick;
    total++; if (mem_valid_out !== 1'b0) begin bad++; $display("FAIL t1_mem_valid_drop got=%b exp=0", mem_valid_out); end
    total++; if (mem_req_out !== 32'h10) begin bad++; $display("FAIL t1_mem_req_hold got=%h exp=10", mem_req_out); end
    mem_valid_in = 1'b1; mem_data_in = 32'hAB;
    tick;
    mem_valid_in = 1'b0;
    total++; if (resp_valid_out !== 4'b0001) begin bad++; $display("FAIL t1_resp got=%b exp=0001", resp_valid_out); end
    total++; if (resp_data_out !== 32'hAB) begin bad++; $display("FAIL t1_data got=%h exp=ab", resp_data_out); end
    total++; if (inflight_out !== 4'd0) begin bad++; $display("FAIL t1_inflight_end got=%0d exp=0", inflight_out); end
    tick;
    total++; if (resp_valid_out !== 4'b0) begin bad++; $display("FAIL t1_resp_drop got=%b exp=0000", resp_valid_out); end
    total++; if (resp_data_out !== 32'hAB) begin bad++; $display("FAIL t1_data_hold got=%h exp=ab", resp_data_out); end
  endtask

  task automatic test_round_robin;
    do_reset;
    for (int r = 0; r < 4; r++) req_addr_in[r] = addr_of(r);
    req_valid_in = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (req_ready_out !== oh(i)) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready_out, oh(i)); end
      tick;
      total++; if (mem_req_out !== addr_of(i % 4) || mem_valid_out !== 1'b1) begin bad++; $display("FAIL rr_mem_req[%0d] got=%h/%b exp=%h/1", i, mem_req_out, mem_valid_out, addr_of(i % 4)); end
    end
    req_valid_in = '0;
    total++; if (inflight_out !== 4'd6) begin bad++; $display("FAIL rr_inflight got=%0d exp=6", inflight_out); end
    for (int k = 0; k < 6; k++) begin
      mem_valid_in = 1'b1; mem_data_in = 32'hD0 + 32'(k);
      tick;
      total++; if (resp_valid_out !== oh(k) || resp_data_out !== 32'hD0 + 32'(k)) begin bad++; $display("FAIL rr_resp[%0d] got=%b/%h exp=%b/%h", k, resp_valid_out, resp_data_out, oh(k), 32'hD0 + 32'(k)); end
    end
    mem_valid_in = 1'b0;
    tick;
    total++; if (inflight_out !== 4'd0 || resp_valid_out !== 4'b0) begin bad++; $display("FAIL rr_drain got=%0d/%b exp=0/0000", inflight_out, resp_valid_out); end
  endtask

  task automatic test_full;
    req_valid_in = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (req_ready_out !== oh(2 + i)) begin bad++; $display("FAIL full_ready[%0d] got=%b exp=%b", i, req_ready_out, oh(2 + i)); end
      tick;
    end
    #1;
    total++; if (inflight_out !== 4'd8) begin bad++; $display("FAIL full_inflight got=%0d exp=8", inflight_out); end
    total++; if (req_ready_out !== 4'b0) begin bad++; $display("FAIL full_ready got=%b exp=0000", req_ready_out); end
    tick;
    total++; if (mem_valid_out !== 1'b0 || req_ready_out !== 4'b0) begin bad++; $display("FAIL full_stall got=%b/%b exp=0/0000", mem_valid_out, req_ready_out); end
    mem_valid_in = 1'b1; mem_data_in = 32'h55;
    #1;
    total++; if (req_ready_out !== 4'b0) begin bad++; $display("FAIL full_no_bypass got=%b exp=0000", req_ready_out); end
    tick;
    mem_valid_in = 1'b0;
    #1;
    total++; if (resp_valid_out !== 4'b0100 || resp_data_out !== 32'h55) begin bad++; $display("FAIL full_pop got=%b/%h exp=0100/55", resp_valid_out, resp_data_out); end
    total++; if (inflight_out !== 4'd7 || req_ready_out !== 4'b0100) begin bad++; $display("FAIL full_reopen got=%0d/%b exp=7/0100", inflight_out, req_ready_out); end
    tick;
    req_valid_in = '0;
    total++; if (mem_valid_out !== 1'b1 || mem_req_out !== addr_of(2) || inflight_out !== 4'd8) begin bad++; $display("FAIL full_regrant got=%b/%h/%0d exp=1/%h/8", mem_valid_out, mem_req_out, inflight_out, addr_of(2)); end
    for (int k = 0; k < 8; k++) begin
      mem_valid_in = 1'b1; mem_data_in = 32'h60 + 32'(k);
      tick;
      total++; if (resp_valid_out !== oh(3 + k) || resp_data_out !== 32'h60 + 32'(k)) begin bad++; $display("FAIL full_resp[%0d] got=%b/%h exp=%b/%h", k, resp_valid_out, resp_data_out, oh(3 + k), 32'h60 + 32'(k)); end
    end
    mem_valid_in = 1'b0;
    tick;
    total++; if (inflight_out !== 4'd0) begin bad++; $display("FAIL full_drain got=%0d exp=0", inflight_out); end
  endtask

  task automatic test_err;
    mem_valid_in = 1'b1; mem_data_in = 32'h77;
    tick;
    mem_valid_in = 1'b0;
    total++; if (err_out !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err_out); end
    total++; if (resp_valid_out !== 4'b0 || inflight_out !== 4'd0) begin bad++; $display("FAIL err_drop got=%b/%0d exp=0000/0", resp_valid_out, inflight_out); end
    req_valid_in = 4'b0010; req_addr_in[1] = 32'h44;
    #1;
    total++; if (req_ready_out !== 4'b0010) begin bad++; $display("FAIL err_ready got=%b exp=0010", req_ready_out); end
    tick;
    req_valid_in = '0;
    total++; if (mem_req_out !== 32'h44) begin bad++; $display("FAIL err_mem_req got=%h exp=44", mem_req_out); end
    mem_valid_in = 1'b1; mem_data_in = 32'h99;
    tick;
    mem_valid_in = 1'b0;
    total++; if (resp_valid_out !== 4'b0010 || resp_data_out !== 32'h99) begin bad++; $display("FAIL err_resp got=%b/%h exp=0010/99", resp_valid_out, resp_data_out); end
    total++; if (err_out !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_out); end
    req_addr_in[1] = addr_of(1);
  endtask

  task automatic test_back_to_back;
    req_valid_in = 4'b1111;
    tick; tick; tick;
    req_valid_in = 4'b0010;
    mem_valid_in = 1'b1; mem_data_in = 32'hC3;
    #1;
    total++; if (inflight_out !== 4'd3 || req_ready_out !== 4'b0010) begin bad++; $display("FAIL b2b_pre got=%0d/%b exp=3/0010", inflight_out, req_ready_out); end
    tick;
    req_valid_in = '0; mem_valid_in = 1'b0;
    total++; if (inflight_out !== 4'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", inflight_out); end
    total++; if (resp_valid_out !== 4'b0100 || resp_data_out !== 32'hC3) begin bad++; $display("FAIL b2b_resp got=%b/%h exp=0100/c3", resp_valid_out, resp_data_out); end
    total++; if (mem_valid_out !== 1'b1 || mem_req_out !== addr_of(1)) begin bad++; $display("FAIL b2b_mem got=%b/%h exp=1/%h", mem_valid_out, mem_req_out, addr_of(1)); end
    for (int k = 0; k < 3; k++) begin
      mem_valid_in = 1'b1; mem_data_in = 32'hE0 + 32'(k);
      tick;
      total++; if (resp_valid_out !== oh(3 + k)) begin bad++; $display("FAIL b2b_tail[%0d] got=%b exp=%b", k, resp_valid_out, oh(3 + k)); end
    end
    mem_valid_in = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    req_valid_in = 4'b1111;
    for (int i = 0; i < 5; i++) tick;
    total++; if (inflight_out !== 4'd5 || mem_valid_out !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%b exp=5/1", inflight_out, mem_valid_out); end
    #2;
    rst_in = 1'b0;
    #1;
    total++; if (mem_valid_out !== 1'b0 || mem_req_out !== 32'h0) begin bad++; $display("FAIL mid_mem got=%b/%h exp=0/0", mem_valid_out, mem_req_out); end
    total++; if (inflight_out !== 4'd0 || req_ready_out !== 4'b0) begin bad++; $display("FAIL mid_count got=%0d/%b exp=0/0000", inflight_out, req_ready_out); end
    total++; if (err_out !== 1'b0 || resp_data_out !== 32'h0) begin bad++; $display("FAIL mid_err got=%b/%h exp=0/0", err_out, resp_data_out); end
    req_valid_in = 4'b0100;
    #1;
    rst_in = 1'b1;
    #1;
    total++; if (req_ready_out !== 4'b0100) begin bad++; $display("FAIL mid_first got=%b exp=0100", req_ready_out); end
    tick;
    total++; if (mem_valid_out !== 1'b1 || mem_req_out !== addr_of(2) || inflight_out !== 4'd1) begin bad++; $display("FAIL mid_grant got=%b/%h/%0d exp=1/%h/1", mem_valid_out, mem_req_out, inflight_out, addr_of(2)); end
    req_valid_in = 4'b1111;
    #1;
    total++; if (req_ready_out !== 4'b1000) begin bad++; $display("FAIL mid_ptr got=%b exp=1000", req_ready_out); end
    req_valid_in = '0;
  endtask

  initial begin
    rst_in = 1'b0; req_valid_in = '0; mem_valid_in = 1'b0; mem_data_in = '0;
    for (int r = 0; r < 4; r++) req_addr_in[r] = addr_of(r);
    #3;
    test_reset;
    test_single;
    test_round_robin;
    test_full;
    test_err;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
